// File: rtl/uart_defs.sv
// Purpose: shared UART definitions (FSM encoding, frame constants, default divider) for the TX and RX sides.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_defs;

    // Line state machine shared by transmit and receive paths.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // 50 MHz system clock / 9600 baud.
    localparam int BPS_DIV_DEFAULT = 5208;

    // Baud counter is wide enough for any divider up to 65535.
    localparam int BAUD_W = 16;

    // 8N1 framing.
    localparam int DATA_BITS  = 8;
    localparam int STOP_BITS  = 1;
    localparam int FRAME_BITS = 1 + DATA_BITS + STOP_BITS;

    // Index of the last data bit, sized for a 3-bit bit counter.
    localparam logic [2:0] DATA_BIT_LAST = 3'(DATA_BITS - 1);

endpackage

// File: rtl/uart_sync_fifo.sv
// Purpose: single-clock FIFO with registered full/empty flags and show-ahead read data.
// Latency: a write is visible at rd_dat (and clears empty) on the edge after it is accepted.
// Backpressure: writes while full are dropped; pops while empty are ignored.
//
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   wr_vld, wr_dat    - write strobe and data; accepted when full is low
//   rd_rdy            - consumer takes the head entry this edge (ignored when empty)
//   rd_dat            - head entry, valid whenever empty is low
//   full, empty       - registered occupancy flags
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int         DEPTH     = 1 << AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Both qualifiers use the registered flags, so a pop on the same edge
    // never opens a slot for a write that the full flag already refused.
    assign push = wr_vld && !full;
    assign pop  = rd_rdy && !empty;

    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CNT_ONE;
        end else if (pop && !push) begin
            count_nxt = count - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            count <= count_nxt;
            full  <= (count_nxt == DEPTH_CNT);
            empty <= (count_nxt == '0);
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage holds no control state, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/uart_fifo_tx.sv
// Purpose: byte-wide FIFO feeding an 8N1 UART transmitter.
// Latency: write into an empty FIFO with the line idle drives the start bit two edges later.
// Backpressure: Full_Sig high means the next write is dropped; frames run back-to-back while bytes are queued.
//
// Ports:
//   CLK, RST         - system clock, asynchronous active-high reset
//   Write_Req_Sig    - one-cycle write strobe for FIFO_Write_Data
//   FIFO_Write_Data  - byte to transmit
//   Full_Sig         - FIFO full (registered)
//   Empty_Sig        - FIFO empty (registered)
//   Busy_Sig         - frame on the line (registered, aligned with TX_Pin_Out)
//   TX_Pin_Out       - serial output, idle high (registered)
module uart_fifo_tx
    import uart_defs::*;
#(
    parameter int BPS_DIV = BPS_DIV_DEFAULT,
    parameter int FIFO_AW = 4
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Write_Req_Sig,
    input  logic [7:0] FIFO_Write_Data,
    output logic       Full_Sig,
    output logic       Empty_Sig,
    output logic       Busy_Sig,
    output logic       TX_Pin_Out
);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_DIV - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [2:0]        BIT_ONE   = 3'd1;

    uart_state_t       state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_dat;
    logic [7:0]        head_dat;
    logic              bit_end;
    logic              pop_rdy;

    assign bit_end = (baud_cnt == BAUD_LAST);

    // The FSM wants a new byte whenever it is idle or finishing a stop bit;
    // the FIFO only honours this when it is not empty, matching the FSM's
    // own Empty_Sig test below.
    assign pop_rdy = (state == ST_IDLE) || ((state == ST_STOP) && bit_end);

    uart_sync_fifo #(
        .WIDTH (8),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_vld (Write_Req_Sig),
        .wr_dat (FIFO_Write_Data),
        .rd_rdy (pop_rdy),
        .rd_dat (head_dat),
        .full   (Full_Sig),
        .empty  (Empty_Sig)
    );

    // TX_Pin_Out and Busy_Sig are registered from the current state, so the
    // line lags the state by one clock; each bit still lasts exactly BPS_DIV
    // clocks and Busy_Sig covers exactly the frame as seen on the pin.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_dat  <= '0;
            TX_Pin_Out <= 1'b1;
            Busy_Sig   <= 1'b0;
        end else begin
            Busy_Sig <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    TX_Pin_Out <= 1'b1;
                    if (!Empty_Sig) begin
                        shift_dat <= head_dat;
                        baud_cnt  <= '0;
                        state     <= ST_START;
                    end
                end

                ST_START: begin
                    TX_Pin_Out <= 1'b0;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end

                ST_DATA: begin
                    TX_Pin_Out <= shift_dat[0];
                    if (bit_end) begin
                        baud_cnt  <= '0;
                        shift_dat <= shift_dat >> 1;
                        if (bit_idx == DATA_BIT_LAST) begin
                            state <= ST_STOP;
                        end else begin
                            bit_idx <= bit_idx + BIT_ONE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end

                ST_STOP: begin
                    TX_Pin_Out <= 1'b1;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        // Chain straight into the next start bit when a byte
                        // is waiting, leaving no idle gap between frames.
                        if (!Empty_Sig) begin
                            shift_dat <= head_dat;
                            state     <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end

                default: begin
                    TX_Pin_Out <= 1'b1;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_fifo_tx.sv
// Purpose: self-checking bench for uart_fifo_tx with a cycle-level reference model and line decoder.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_fifo_tx;

    localparam int B     = 4;
    localparam int DEPTH = 16;

    logic       CLK;
    logic       RST;
    logic       Write_Req_Sig;
    logic [7:0] FIFO_Write_Data;
    logic       Full_Sig;
    logic       Empty_Sig;
    logic       Busy_Sig;
    logic       TX_Pin_Out;

    uart_fifo_tx #(
        .BPS_DIV (B),
        .FIFO_AW (4)
    ) dut (
        .CLK             (CLK),
        .RST             (RST),
        .Write_Req_Sig   (Write_Req_Sig),
        .FIFO_Write_Data (FIFO_Write_Data),
        .Full_Sig        (Full_Sig),
        .Empty_Sig       (Empty_Sig),
        .Busy_Sig        (Busy_Sig),
        .TX_Pin_Out      (TX_Pin_Out)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // Reference model: queued bytes plus the number of clocks left in the
    // frame currently being sent (0 = line idle).
    logic [7:0] q[$];
    int         rem;
    logic [7:0] cur;
    logic       exp_tx;
    logic       exp_busy;

    // Line decoder fed from sampled TX_Pin_Out.
    logic       dec_active;
    int         dec_t;
    logic [7:0] dec_byte;
    logic [7:0] got[$];

    typedef struct {
        logic [7:0] dat;
        logic [9:0] frame;   // bit 0 = start bit ... bit 9 = stop bit
    } vec_t;

    vec_t tbl[6];

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        rem        = 0;
        cur        = 8'h00;
        exp_tx     = 1'b1;
        exp_busy   = 1'b0;
        dec_active = 1'b0;
        dec_t      = 0;
        dec_byte   = 8'h00;
    endtask

    // One rising edge of the abstract transmitter.
    task automatic model_edge(input logic w, input logic [7:0] d);
        logic wr_ok;
        logic do_pop;
        int   k;
        wr_ok  = w && (q.size() < DEPTH);
        do_pop = (rem <= 1) && (q.size() > 0);
        // Pin shows the frame position reached before this edge.
        if (rem == 0) begin
            exp_tx = 1'b1;
        end else begin
            k = (10 * B - rem) / B;
            if (k == 0)      exp_tx = 1'b0;
            else if (k <= 8) exp_tx = cur[k-1];
            else             exp_tx = 1'b1;
        end
        exp_busy = (rem > 0);
        if (rem > 0) rem--;
        if (do_pop) begin
            cur = q.pop_front();
            rem = 10 * B;
        end
        if (wr_ok) q.push_back(d);
    endtask

    task automatic decode(input logic line);
        int idx;
        if (!dec_active) begin
            if (line == 1'b0) begin
                dec_active = 1'b1;
                dec_t      = 0;
            end
        end else begin
            dec_t++;
            if (dec_t >= B + B / 2 && dec_t <= 8 * B + B / 2 && ((dec_t - B / 2) % B) == 0) begin
                idx = (dec_t - B / 2) / B - 1;
                dec_byte[idx] = line;
            end else if (dec_t == 9 * B + B / 2) begin
                if (line) got.push_back(dec_byte);
                dec_active = 1'b0;
            end
        end
    endtask

    task automatic cycle(input logic w, input logic [7:0] d);
        Write_Req_Sig   = w;
        FIFO_Write_Data = d;
        @(posedge CLK);
        model_edge(w, d);
        #1;
        check_bit("tx_line", TX_Pin_Out, exp_tx);
        check_bit("busy", Busy_Sig, exp_busy);
        check_bit("full", Full_Sig, q.size() == DEPTH);
        check_bit("empty", Empty_Sig, q.size() == 0);
        decode(TX_Pin_Out);
        Write_Req_Sig = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((rem != 0 || q.size() != 0) && n < limit) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        cycle(1'b0, 8'h00);
        cycle(1'b0, 8'h00);
        if (n >= limit) check_int("wait_idle_timeout", n, -1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react before any edge.
    task automatic do_reset();
        #2;
        RST = 1'b1;
        #1;
        check_bit("rst_tx", TX_Pin_Out, 1'b1);
        check_bit("rst_empty", Empty_Sig, 1'b1);
        check_bit("rst_full", Full_Sig, 1'b0);
        check_bit("rst_busy", Busy_Sig, 1'b0);
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int first_low;
        int busy_n;
        int n;
        logic [9:0] frame;
        int rate;

        tbl[0] = '{8'h55, 10'h2AA};
        tbl[1] = '{8'h00, 10'h200};
        tbl[2] = '{8'hFF, 10'h3FE};
        tbl[3] = '{8'h80, 10'h300};
        tbl[4] = '{8'h01, 10'h202};
        tbl[5] = '{8'hA5, 10'h34A};

        RST             = 1'b1;
        Write_Req_Sig   = 1'b0;
        FIFO_Write_Data = 8'h00;
        model_reset();
        repeat (3) @(posedge CLK);
        do_reset();

        // Idle line after reset release.
        for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00);

        // Single-byte frames: latency, bit pattern, busy length.
        for (int v = 0; v < 6; v++) begin
            wait_idle(200);
            cycle(1'b1, tbl[v].dat);
            first_low = -1;
            busy_n    = 0;
            frame     = '0;
            for (int t = 1; t <= 50; t++) begin
                cycle(1'b0, 8'h00);
                if (TX_Pin_Out == 1'b0 && first_low < 0) first_low = t;
                if (Busy_Sig) busy_n++;
                if (t >= 3 && ((t - 3) % B) == 0 && (t - 3) / B < 10) frame[(t - 3) / B] = TX_Pin_Out;
            end
            check_int("start_latency", first_low, 2);
            check_int("busy_cycles", busy_n, 10 * B);
            check_int("frame_bits", int'(frame), int'(tbl[v].frame));
        end

        // Fill past capacity, then collide a write with a pop while full.
        wait_idle(200);
        got.delete();
        for (int i = 0; i < 18; i++) cycle(1'b1, 8'(i));
        check_bit("full_after_fill", Full_Sig, 1'b1);
        n = 0;
        while (!(rem == 1 && q.size() == DEPTH) && n < 100) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        if (n >= 100) check_int("full_pop_edge_timeout", n, -1);
        cycle(1'b1, 8'hAA);
        check_bit("full_after_collide", Full_Sig, 1'b0);
        check_bit("empty_after_collide", Empty_Sig, 1'b0);
        wait_idle(2000);
        check_int("burst_frame_count", got.size(), 17);
        for (int i = 0; i < 17 && i < got.size(); i++) check_int("burst_byte", int'(got[i]), i);
        check_bit("burst_empty_end", Empty_Sig, 1'b1);

        // Reset in the middle of a data bit with bytes still queued.
        wait_idle(200);
        got.delete();
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'h01);
        cycle(1'b1, 8'h02);
        cycle(1'b1, 8'h03);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00);
        check_bit("pre_reset_tx_low", TX_Pin_Out, 1'b0);
        do_reset();
        for (int i = 0; i < 100; i++) cycle(1'b0, 8'h00);
        check_int("frames_after_reset", got.size(), 0);

        // Write landing on the last stop clock of a frame.
        wait_idle(200);
        got.delete();
        cycle(1'b1, 8'h3C);
        n = 0;
        while (!(rem == 1 && q.size() == 0) && n < 100) begin
            cycle(1'b0, 8'h00);
            n++;
        end
        if (n >= 100) check_int("last_stop_timeout", n, -1);
        cycle(1'b1, 8'hA5);
        first_low = -1;
        for (int t = 1; t <= 10; t++) begin
            cycle(1'b0, 8'h00);
            if (TX_Pin_Out == 1'b0 && first_low < 0) first_low = t;
        end
        check_int("a5_start_delay", first_low, 2);
        wait_idle(200);
        check_int("a5_frame_count", got.size(), 2);
        if (got.size() == 2) begin
            check_int("a5_first_byte", int'(got[0]), 8'h3C);
            check_int("a5_second_byte", int'(got[1]), 8'hA5);
        end

        // Randomised traffic: sparse then heavy.
        for (int ph = 0; ph < 2; ph++) begin
            rate = (ph == 0) ? 3 : 30;
            for (int i = 0; i < 1500; i++) begin
                cycle($urandom_range(0, 99) < rate, 8'($urandom_range(0, 255)));
            end
        end
        wait_idle(2000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_fifo_tx.md
UART_FIFO_TX -- requirements
Module: uart_fifo_tx

Interface
REQ-001 SHALL have parameter BPS_DIV, default 5208, meaning clocks per UART bit (50 MHz / 9600 baud); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_AW, default 4, meaning FIFO address width (depth 2**FIFO_AW = 16 bytes).
REQ-003 SHALL have port CLK  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  reset; asynchronous, active-high.
REQ-005 SHALL have port Write_Req_Sig  input  1  one-cycle byte write strobe.
REQ-006 SHALL have port FIFO_Write_Data  input  8  byte to send; sampled when Write_Req_Sig=1.
REQ-007 SHALL have port Full_Sig  output  1  FIFO holds 2**FIFO_AW bytes; registered.
REQ-008 SHALL have port Empty_Sig  output  1  FIFO holds 0 bytes; registered.
REQ-009 SHALL have port Busy_Sig  output  1  a frame is on the line (state != IDLE).
REQ-010 SHALL have port TX_Pin_Out  output  1  serial line, idle high, registered.

Function
REQ-011 SHALL frame each byte 8N1: start bit 0, data bits LSB first, one stop bit 1; each bit exactly BPS_DIV clocks.
REQ-012 SHALL accept a write on an edge where Write_Req_Sig=1 and Full_Sig=0; write with Full_Sig=1 SHALL be dropped, no state change.
REQ-013 SHALL evaluate Full_Sig from the registered count before the edge; a pop on the same edge SHALL NOT allow a write that was blocked by Full_Sig=1.
REQ-014 SHALL keep occupancy count of FIFO_AW+1 bits; simultaneous accepted write and pop SHALL leave count unchanged; pointers SHALL wrap modulo 2**FIFO_AW.
REQ-015 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-016 IDLE: if Empty_Sig=0, SHALL pop head byte into 8-bit shift register, clear baud counter, go START; else stay, TX_Pin_Out=1.
REQ-017 START: TX_Pin_Out=0 for BPS_DIV clocks, then DATA with bit index 0.
REQ-018 DATA: TX_Pin_Out=shift[0] per bit; shift right at each bit boundary; after bit index 7 completes, go STOP.
REQ-019 STOP: TX_Pin_Out=1 for BPS_DIV clocks; on last STOP clock, if Empty_Sig=0 SHALL pop and go START directly (zero idle gap), else go IDLE.
REQ-020 Latency: write accepted on edge N into empty FIFO with FSM IDLE SHALL drive TX_Pin_Out=0 from edge N+2.
REQ-021 Baud counter SHALL count 0..BPS_DIV-1 and reset at every bit boundary; no fractional accumulation.
REQ-022 Busy_Sig SHALL be 1 from first START clock through last STOP clock: 10*BPS_DIV clocks per frame.
REQ-023 Writes during transmission SHALL NOT disturb the frame in progress.

Reset
REQ-024 RST=1 SHALL asynchronously force: TX_Pin_Out=1, Full_Sig=0, Empty_Sig=1, Busy_Sig=0, FSM=IDLE, count/pointers/baud counter/bit index=0, shift register=0.
REQ-025 RST mid-frame SHALL abort the frame, drive the line high immediately and flush the FIFO; no partial frame resumes after release.
REQ-026 FIFO storage array need not be reset.

Structure
REQ-027 Shared package uart_defs SHALL hold FSM state encoding, default BPS_DIV, frame constants (DATA_BITS=8, STOP_BITS=1); reused by the receive side.
REQ-028 FIFO SHALL be one sub-module uart_sync_fifo (parameterised width/depth, registered full/empty, show-ahead read data); FSM and baud logic in uart_fifo_tx.
REQ-029 Target 120-400 lines RTL total; no vendor megafunctions.

Verification (BPS_DIV=4)
REQ-030 Reset release -> TX_Pin_Out=1, Empty_Sig=1, Full_Sig=0, Busy_Sig=0, line high for 100 clocks with no writes.
REQ-031 Single write 0x55 at edge N -> TX low from N+2 for 4 clocks, then 1,0,1,0,1,0,1,0 each 4 clocks, stop high 4 clocks; Busy_Sig high exactly 40 clocks.
REQ-032 18 consecutive writes 0x00..0x11 while idle -> first popped, next 16 fill FIFO, Full_Sig=1, 0x11 dropped; 17 frames 0x00..0x10 back-to-back, no idle gap, Empty_Sig=1 at end.
REQ-033 FIFO full and FSM popping on same edge as write 0xAA -> 0xAA dropped; count 15 after edge.
REQ-034 RST pulsed mid-DATA of 0x00 with 3 bytes queued -> TX_Pin_Out=1 same cycle, Empty_Sig=1, no frame after release.
REQ-035 Write 0xA5 on last STOP clock of a frame with FIFO otherwise empty -> next START begins on following edge, byte 0xA5 transmitted correctly.
